// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared constants, types and helpers for the sprite motion controller.
//   H_ACTIVE / V_ACTIVE : visible raster size (1280 x 720)
//   state_t             : scheduler states IDLE -> STEP_X -> STEP_Y -> COMMIT
//   vel_t               : default-width signed velocity (pixels/frame)
//   clamp_pos()         : clamp a coordinate into [lo, hi]
// ---------------------------------------------------------------------------
package sprite_pkg;

    localparam int H_ACTIVE  = 1280;
    localparam int V_ACTIVE  = 720;
    localparam int VEL_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef logic signed [VEL_W_DEF-1:0] vel_t;

    function automatic logic [10:0] clamp_pos(input logic [10:0] p,
                                              input logic [10:0] lo,
                                              input logic [10:0] hi);
        if (p < lo)
            return lo;
        else if (p > hi)
            return hi;
        else
            return p;
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// ---------------------------------------------------------------------------
// sprite_motion_ctrl_if
// Configuration port of the sprite motion controller.
//   cfg_valid / cfg_ready : handshake
//   cfg_x, cfg_y          : new centre position
//   cfg_vx, cfg_vy        : new signed velocities
// Handshake: the master raises cfg_valid with stable fields and holds them
// until a cycle where cfg_ready is also high; the transfer happens on that
// rising clock edge. cfg_ready never depends on cfg_valid.
// Modports: master (config source), slave (sprite_motion_ctrl).
// ---------------------------------------------------------------------------
interface sprite_motion_ctrl_if #(
    parameter int VEL_W = 6
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [10:0]             cfg_x;
    logic [9:0]              cfg_y;
    logic signed [VEL_W-1:0] cfg_vx;
    logic signed [VEL_W-1:0] cfg_vy;

    modport master (output cfg_valid, cfg_x, cfg_y, cfg_vx, cfg_vy,
                    input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_x, cfg_y, cfg_vx, cfg_vy,
                    output cfg_ready);
endinterface

// File: rtl/axis_step.sv
// ---------------------------------------------------------------------------
// axis_step
// Combinational one-axis position update, shared by X and Y.
//   i_pos, i_vel        : current position and (signed) velocity
//   i_active, i_radius  : axis size and edge margin; legal range is
//                         [i_radius, i_active-1-i_radius]
//   i_load, i_load_pos  : replace the step by a direct load (velocity passes)
//   o_pos, o_vel, o_hit : next position, next velocity, edge event
// Macro SPRITE_WRAP_EN: edges wrap around instead of bouncing.
// ---------------------------------------------------------------------------
module axis_step #(
    parameter int VEL_W = 6
) (
    input  logic [10:0]             i_pos,
    input  logic signed [VEL_W-1:0] i_vel,
    input  logic [10:0]             i_active,
    input  logic [10:0]             i_radius,
    input  logic                    i_load,
    input  logic [10:0]             i_load_pos,
    output logic [10:0]             o_pos,
    output logic signed [VEL_W-1:0] o_vel,
    output logic                    o_hit
);
    logic signed [12:0] w_nxt;
    logic signed [12:0] w_lo;
    logic signed [12:0] w_hi;
    logic signed [12:0] w_act;
`ifndef SPRITE_WRAP_EN
    logic signed [VEL_W-1:0] w_neg;
`endif

    always_comb begin
        // 13-bit signed sum cannot overflow for an 11-bit position
        w_nxt = signed'({2'b00, i_pos}) + signed'({{(13-VEL_W){i_vel[VEL_W-1]}}, i_vel});
        w_act = signed'({2'b00, i_active});
        w_lo  = signed'({2'b00, i_radius});
        w_hi  = w_act - w_lo - 13'sd1;
`ifndef SPRITE_WRAP_EN
        // most negative velocity saturates instead of wrapping back to itself
        w_neg = (i_vel == {1'b1, {(VEL_W-1){1'b0}}}) ? {1'b0, {(VEL_W-1){1'b1}}} : -i_vel;
`endif
        o_pos = 11'(w_nxt);
        o_vel = i_vel;
        o_hit = 1'b0;
        if (i_load) begin
            o_pos = i_load_pos;
        end else if (w_nxt < w_lo) begin
            o_hit = 1'b1;
`ifdef SPRITE_WRAP_EN
            o_pos = 11'(w_nxt + w_act);
`else
            o_pos = i_radius;
            o_vel = w_neg;
`endif
        end else if (w_nxt > w_hi) begin
            o_hit = 1'b1;
`ifdef SPRITE_WRAP_EN
            o_pos = 11'(w_nxt - w_act);
`else
            o_pos = 11'(w_hi);
            o_vel = w_neg;
`endif
        end
    end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_motion_ctrl
// Per-frame scheduler for the sprite centre. At start of vertical blank
// (hcount=1280, vcount=720) it runs X step, Y step, then commits both axes.
//   clk_in, rst_in         : pixel clock, async active-high reset
//   hcount_in, vcount_in   : raster position from the timing generator
//   pause_in               : freeze motion (sampled at frame start)
//   cfg                    : config handshake (sprite_motion_ctrl_if.slave)
//   x_out, y_out           : committed centre, stable during active video
//   bounce_out             : one-cycle pulse at commit on any edge event
//   state_out              : current scheduler state (debug)
// Macro SPRITE_WRAP_EN: edges wrap; legal range becomes the full screen.
// ---------------------------------------------------------------------------
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int RADIUS  = 64,
    parameter int INIT_VX = 2,
    parameter int INIT_VY = 1,
    parameter int VEL_W   = VEL_W_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic                 pause_in,
    sprite_motion_ctrl_if.slave  cfg,
    output logic [10:0]          x_out,
    output logic [9:0]           y_out,
    output logic                 bounce_out,
    output state_t               state_out
);
`ifdef SPRITE_WRAP_EN
    localparam int EFF_R = 0;
`else
    localparam int EFF_R = RADIUS;
`endif
    localparam logic [10:0] X_LO = 11'(EFF_R);
    localparam logic [10:0] X_HI = 11'(H_ACTIVE - 1 - EFF_R);
    localparam logic [10:0] Y_LO = 11'(EFF_R);
    localparam logic [10:0] Y_HI = 11'(V_ACTIVE - 1 - EFF_R);

    state_t r_state, w_next;

    logic [10:0]             r_x, r_wx, r_cfg_x;
    logic [9:0]              r_y, r_wy, r_cfg_y;
    logic signed [VEL_W-1:0] r_vx, r_vy, r_cfg_vx, r_cfg_vy;
    logic                    r_pending, r_load, r_pause, r_hit, r_bounce;

    logic                    w_frame_start, w_xfer, w_is_x, w_hit;
    logic [10:0]             w_step_pos, w_active, w_load_pos, w_new_pos;
    logic signed [VEL_W-1:0] w_step_vel, w_new_vel;

    assign w_frame_start = (hcount_in == 11'(H_ACTIVE)) && (vcount_in == 10'(V_ACTIVE));
    assign cfg.cfg_ready = !rst_in && (r_state == IDLE) && !r_pending;
    assign w_xfer        = cfg.cfg_valid && cfg.cfg_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_frame_start) w_next = STEP_X;
            STEP_X:  w_next = STEP_Y;
            STEP_Y:  w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shared axis unit: operand selection by state. A load frame uses the
    // config velocity; a paused frame steps by zero.
    always_comb begin
        w_is_x     = (r_state == STEP_X);
        w_step_pos = w_is_x ? r_x : {1'b0, r_y};
        w_active   = w_is_x ? 11'(H_ACTIVE) : 11'(V_ACTIVE);
        w_load_pos = w_is_x ? clamp_pos(r_cfg_x, X_LO, X_HI)
                            : clamp_pos({1'b0, r_cfg_y}, Y_LO, Y_HI);
        if (r_load)
            w_step_vel = w_is_x ? r_cfg_vx : r_cfg_vy;
        else if (r_pause)
            w_step_vel = '0;
        else
            w_step_vel = w_is_x ? r_vx : r_vy;
    end

    axis_step #(.VEL_W(VEL_W)) u_axis_step (
        .i_pos      (w_step_pos),
        .i_vel      (w_step_vel),
        .i_active   (w_active),
        .i_radius   (11'(EFF_R)),
        .i_load     (r_load),
        .i_load_pos (w_load_pos),
        .o_pos      (w_new_pos),
        .o_vel      (w_new_vel),
        .o_hit      (w_hit)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_x       <= 11'(H_ACTIVE / 2);
            r_y       <= 10'(V_ACTIVE / 2);
            r_wx      <= 11'(H_ACTIVE / 2);
            r_wy      <= 10'(V_ACTIVE / 2);
            r_vx      <= VEL_W'(INIT_VX);
            r_vy      <= VEL_W'(INIT_VY);
            r_cfg_x   <= '0;
            r_cfg_y   <= '0;
            r_cfg_vx  <= '0;
            r_cfg_vy  <= '0;
            r_pending <= 1'b0;
            r_load    <= 1'b0;
            r_pause   <= 1'b0;
            r_hit     <= 1'b0;
            r_bounce  <= 1'b0;
        end else begin
            r_bounce <= 1'b0;
            if (w_xfer) begin
                r_pending <= 1'b1;
                r_cfg_x   <= cfg.cfg_x;
                r_cfg_y   <= cfg.cfg_y;
                r_cfg_vx  <= cfg.cfg_vx;
                r_cfg_vy  <= cfg.cfg_vy;
            end
            case (r_state)
                IDLE: begin
                    // A transfer on the frame-start cycle is not seen here
                    // (old r_pending), so it waits for the next frame.
                    if (w_frame_start) begin
                        r_load  <= r_pending;
                        r_pause <= pause_in;
                    end
                end
                STEP_X: begin
                    r_wx  <= w_new_pos;
                    r_hit <= w_hit;
                    if (r_load || !r_pause) r_vx <= w_new_vel;
                end
                STEP_Y: begin
                    r_wy  <= w_new_pos[9:0];
                    r_hit <= r_hit | w_hit;
                    if (r_load || !r_pause) r_vy <= w_new_vel;
                end
                COMMIT: begin
                    r_x      <= r_wx;
                    r_y      <= r_wy;
                    r_bounce <= r_hit;
                    if (r_load) r_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign x_out      = r_x;
    assign y_out      = r_y;
    assign bounce_out = r_bounce;
    assign state_out  = r_state;
endmodule
